// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register select indices, SR/Cause bit positions
// and the processor ID constant.
package cp0_pkg;

  localparam int HWINT_W = 6;

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // IM in SR and IP in Cause share the same bit field
  localparam int IM_HI   = 15;
  localparam int IM_LO   = 10;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  localparam logic [31:0] CP0_PRID = 32'h0042_1001;

endpackage

// File: rtl/cp0_hwint_sync.sv
// Two-flop synchronizer bringing the asynchronous device interrupt lines
// into the clk domain.
module cp0_hwint_sync
  import cp0_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [HWINT_W-1:0] hwint,
  output logic [HWINT_W-1:0] ip
);

  logic [HWINT_W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      ip   <= '0;
    end else begin
      meta <= hwint;
      ip   <= meta;
    end
  end

endmodule

// File: rtl/cp0_coproc.sv
// CP0 coprocessor: SR, Cause, EPC and PRId registers with interrupt
// request generation for the main controller.
module cp0_coproc
  import cp0_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [4:0]         sel,
  input  logic [31:0]        din,
  input  logic [29:0]        pc,
  input  logic               epcwr,
  input  logic               exlset,
  input  logic               exlclr,
  input  logic [HWINT_W-1:0] hwint,
  output logic [31:0]        dout,
  output logic [31:0]        epc,
  output logic               intreq
);

  logic [HWINT_W-1:0] im;
  logic               exl;
  logic               ie;
  logic [29:0]        epc_q;
  logic [HWINT_W-1:0] ip;
  logic [31:0]        sr;
  logic [31:0]        cause;
  logic               wr_sr;
  logic               wr_epc;

  cp0_hwint_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .hwint (hwint),
    .ip    (ip)
  );

  assign wr_sr  = we && (sel == SEL_SR);
  assign wr_epc = we && (sel == SEL_EPC);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im    <= '0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      epc_q <= '0;
    end else begin
      if (wr_sr) begin
        im <= din[IM_HI:IM_LO];
        ie <= din[IE_BIT];
      end
      // Interrupt entry must win over eret and software writes to EXL
      if (exlset)
        exl <= 1'b1;
      else if (exlclr)
        exl <= 1'b0;
      else if (wr_sr)
        exl <= din[EXL_BIT];
      if (epcwr)
        epc_q <= pc;
      else if (wr_epc)
        epc_q <= din[31:2];
    end
  end

  always_comb begin
    sr                = '0;
    sr[IM_HI:IM_LO]   = im;
    sr[EXL_BIT]       = exl;
    sr[IE_BIT]        = ie;
    cause             = '0;
    cause[IM_HI:IM_LO] = ip;
  end

  assign epc    = {epc_q, 2'b00};
  assign intreq = ie & ~exl & (|(ip & im));

  always_comb begin
    dout = '0;
    case (sel)
      SEL_SR:    dout = sr;
      SEL_CAUSE: dout = cause;
      SEL_EPC:   dout = epc;
      SEL_PRID:  dout = CP0_PRID;
      default:   dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_coproc.sv
// Scoreboard bench for cp0_coproc: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_cp0_coproc;

  localparam logic [31:0] PRID = 32'h0042_1001;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  sel;
  logic [31:0] din;
  logic [29:0] pc;
  logic        epcwr;
  logic        exlset;
  logic        exlclr;
  logic [5:0]  hwint;
  logic [31:0] dout;
  logic [31:0] epc;
  logic        intreq;

  typedef struct {
    string       name;
    logic [31:0] dout_exp;
    logic [31:0] epc_exp;
    logic        intreq_exp;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  cp0_coproc dut (
    .clk    (clk),
    .reset  (reset),
    .we     (we),
    .sel    (sel),
    .din    (din),
    .pc     (pc),
    .epcwr  (epcwr),
    .exlset (exlset),
    .exlclr (exlclr),
    .hwint  (hwint),
    .dout   (dout),
    .epc    (epc),
    .intreq (intreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks += 3;
      if (dout !== e.dout_exp) begin
        n_fail++;
        $display("FAIL %s dout: got %h expected %h", e.name, dout, e.dout_exp);
      end
      if (epc !== e.epc_exp) begin
        n_fail++;
        $display("FAIL %s epc: got %h expected %h", e.name, epc, e.epc_exp);
      end
      if (intreq !== e.intreq_exp) begin
        n_fail++;
        $display("FAIL %s intreq: got %b expected %b", e.name, intreq, e.intreq_exp);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation for the current cycle, then advance one edge
  task automatic check(input string n, input logic [4:0] s, input logic [31:0] d,
                       input logic [31:0] e, input logic i);
    exp_t x;
    sel          = s;
    x.name       = n;
    x.dout_exp   = d;
    x.epc_exp    = e;
    x.intreq_exp = i;
    sb.push_back(x);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; sel = 5'd0; din = '0; pc = '0;
    epcwr = 1'b0; exlset = 1'b0; exlclr = 1'b0; hwint = '0;
    tick(); tick();

    check("rst_held_prid", 15, PRID, 32'h0, 1'b0);
    check("rst_held_sr",   12, 32'h0, 32'h0, 1'b0);
    reset = 1'b0;

    check("post_rst_sr",    12, 32'h0, 32'h0, 1'b0);
    check("post_rst_cause", 13, 32'h0, 32'h0, 1'b0);
    check("post_rst_epc",   14, 32'h0, 32'h0, 1'b0);
    check("post_rst_prid",  15, PRID,  32'h0, 1'b0);

    we = 1'b1; sel = 12; din = 32'h0000_0401; tick(); we = 1'b0;
    hwint = 6'b000001;
    check("ip_edge0", 13, 32'h0,   32'h0, 1'b0);
    check("ip_edge1", 13, 32'h0,   32'h0, 1'b0);
    check("ip_edge2", 13, 32'h400, 32'h0, 1'b1);

    hwint = 6'b000010; tick(); tick();
    check("ip_masked", 13, 32'h800, 32'h0, 1'b0);
    hwint = 6'b000001; tick(); tick();
    check("intreq_back", 12, 32'h401, 32'h0, 1'b1);

    pc = 30'h0000_0C01; epcwr = 1'b1; exlset = 1'b1; tick();
    epcwr = 1'b0; exlset = 1'b0;
    check("exl_entry", 12, 32'h403, 32'h3004, 1'b0);
    exlclr = 1'b1; tick();
    check("exlclr_hold", 12, 32'h401, 32'h3004, 1'b1);
    exlclr = 1'b0;
    check("exlclr_idem", 12, 32'h401, 32'h3004, 1'b1);

    we = 1'b1; din = 32'h0000_0400;
    check("rd_during_wr", 12, 32'h401, 32'h3004, 1'b1);
    we = 1'b0;
    check("wr_visible", 12, 32'h400, 32'h3004, 1'b0);
    we = 1'b1; sel = 12; din = 32'h0000_0401; tick();
    check("wr_repeat", 12, 32'h401, 32'h3004, 1'b1);
    we = 1'b0;
    check("wr_idem", 12, 32'h401, 32'h3004, 1'b1);

    we = 1'b1; sel = 14; din = 32'h1234_5678; epcwr = 1'b1; pc = 30'h1; tick();
    we = 1'b0; epcwr = 1'b0;
    check("epc_prio", 14, 32'h4, 32'h4, 1'b1);
    we = 1'b1; sel = 12; din = 32'h0000_0401; exlset = 1'b1; tick();
    we = 1'b0; exlset = 1'b0;
    check("exlset_prio", 12, 32'h403, 32'h4, 1'b0);
    we = 1'b1; sel = 12; din = 32'h0000_0403; exlclr = 1'b1; tick();
    we = 1'b0; exlclr = 1'b0;
    check("exlclr_prio", 12, 32'h401, 32'h4, 1'b1);
    we = 1'b1; sel = 14; din = 32'h1234_5677; tick(); we = 1'b0;
    check("epc_wr", 14, 32'h1234_5674, 32'h1234_5674, 1'b1);

    we = 1'b1; din = 32'hFFFF_FFFF;
    sel = 13; tick();
    sel = 15; tick();
    sel = 20; tick();
    we = 1'b0;
    check("cause_ro", 13, 32'h400, 32'h1234_5674, 1'b1);
    check("prid_ro",  15, PRID,    32'h1234_5674, 1'b1);
    check("unmapped", 20, 32'h0,   32'h1234_5674, 1'b1);
    check("sr_kept",  12, 32'h401, 32'h1234_5674, 1'b1);

    exlset = 1'b1; tick(); exlset = 1'b0;
    check("exl_before_rst", 12, 32'h403, 32'h1234_5674, 1'b0);
    #1 reset = 1'b1;
    check("rst_async_sr",    12, 32'h0, 32'h0, 1'b0);
    check("rst_async_epc",   14, 32'h0, 32'h0, 1'b0);
    check("rst_async_cause", 13, 32'h0, 32'h0, 1'b0);
    check("rst_async_prid",  15, PRID,  32'h0, 1'b0);
    reset = 1'b0;

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_coproc.md
CP0_COPROC -- requirements
Module: cp0_coproc

Interface
REQ-001 clk  input  1  system clock; all state updates on the rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 we  input  1  register write enable (mtc0); may stay high for several consecutive cycles.
REQ-004 sel  input  5  register select (instruction bits 15:11), used for both read and write.
REQ-005 din  input  32  write data (GPR rt value).
REQ-006 pc  input  30  word address of the return PC (bits 31:2), captured by epcwr.
REQ-007 epcwr  input  1  EPC capture strobe, asserted in the interrupt-entry state.
REQ-008 exlset  input  1  set SR.EXL on interrupt entry.
REQ-009 exlclr  input  1  clear SR.EXL (eret); may stay high for several cycles.
REQ-010 hwint  input  6  asynchronous device interrupt lines, level-sensitive, active-high.
REQ-011 dout  output  32  combinational read data for the selected register.
REQ-012 epc  output  32  current EPC value, feeds the NPC on eret.
REQ-013 intreq  output  1  interrupt request to the main controller.

Function
REQ-014 Register map: sel 12 = SR, 13 = Cause, 14 = EPC, 15 = PRId; any other sel reads 32'h0 and ignores writes.
REQ-015 SR layout: IM[15:10], EXL[1], IE[0]; all other bits read 0 and are not writable.
REQ-016 Cause layout: IP[15:10] read-only (synchronized hwint); all other bits read 0; writes to Cause are ignored.
REQ-017 EPC holds a word-aligned address; bits[1:0] always read 0.
REQ-018 PRId is a read-only constant, CP0_PRID = 32'h0042_1001; writes to PRId are ignored.
REQ-019 When we=1 and sel=12 at a clock edge, IM <= din[15:10], IE <= din[0], and EXL <= din[1] unless overridden per REQ-022.
REQ-020 When we=1 and sel=14 at a clock edge, EPC[31:2] <= din[31:2], unless overridden per REQ-023.
REQ-021 When epcwr=1 at a clock edge, EPC[31:2] <= pc.
REQ-022 EXL priority at a clock edge, highest first: exlset -> 1; exlclr -> 0; mtc0 write to SR -> din[1]; otherwise hold.
REQ-023 EPC priority at a clock edge: epcwr over mtc0 write.
REQ-024 hwint passes through a 2-flop synchronizer into IP; a change on hwint becomes visible in IP and intreq on the 2nd rising edge after it is sampled.
REQ-025 intreq = IE & ~EXL & |(IP & IM), combinational from registered state with no extra latency.
REQ-026 intreq deasserts in the cycle after the edge where exlset is applied, which blocks nested interrupts.
REQ-027 dout is combinational from sel; a read in the same cycle as a write returns the old value, and the new value is visible after the edge.
REQ-028 Repeated we or exlclr over several cycles with identical inputs is idempotent.

Reset
REQ-029 On reset: SR = 0 (IE=0, EXL=0, IM=0), EPC = 0, synchronizer flops = 0, IP = 0.
REQ-030 While reset is held: intreq = 0, epc = 32'h0, dout reads PRId correctly and all other registers read 0.
REQ-031 Reset asserted mid-operation (including EXL=1 or a pending IP) clears all state immediately and does not wait for a clock edge.

Structure
REQ-032 Shared package cp0_pkg holds: register indices (12..15), SR/Cause bit positions (IM/IP 15:10, EXL 1, IE 0), and CP0_PRID.
REQ-033 One sub-module, cp0_hwint_sync, implements the 6-bit 2-flop synchronizer with asynchronous reset; the remaining logic is flat in cp0_coproc.

Verification
REQ-034 Reset, then read sel 12/13/14/15 -> dout = 0 / 0 / 0 / 32'h0042_1001; intreq = 0.
REQ-035 mtc0 SR with din = 32'h0000_0401, then raise hwint[0] -> IP[10]=1 and intreq=1 exactly 2 edges later; with hwint[1] only, intreq stays 0.
REQ-036 With intreq=1 and pc = 30'h0000_0C01, pulse epcwr and exlset together -> epc = 32'h0000_3004, SR.EXL = 1, intreq = 0 next cycle; then exlclr -> EXL = 0 and intreq = 1 again while hwint[0] is held.
REQ-037 Same-cycle conflicts: mtc0 EPC with din = 32'h1234_5678 plus epcwr with pc = 30'h1 -> epc = 32'h0000_0004; mtc0 SR with din[1]=0 plus exlset -> EXL = 1.
REQ-038 Writes to sel 13, 15 and 20 with din = 32'hFFFF_FFFF -> readback is unchanged (0 / PRId / 0).
REQ-039 Assert reset asynchronously between edges while EXL = 1 and EPC is nonzero -> all registers are 0 and intreq = 0 before the next clock edge.
